// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: receiver state encoding
// and oversampling tick positions used by the 16x bit timing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } rx_state_t;

    localparam int         OVERSAMPLE = 16;
    localparam logic [4:0] MID_TICK   = 5'd7;
    localparam logic [4:0] LAST_TICK  = 5'(OVERSAMPLE - 1);

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Ports: clk, reset (async, active-high), rx (async in), rx_s (synced out).
// Both flops reset to 1 so an idle line never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= rx;
            r_sync <= r_meta;
        end
    end

    assign rx_s = r_sync;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer on a 16x oversample tick with valid/ready output
// buffer. Ports: clk, reset (async high), s_tick, rx, rx_ready in;
// rx_valid, dout, frame_err, parity_err, overrun_err, busy out.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    input  logic            rx_ready,
    output logic            rx_valid,
    output logic [DBIT-1:0] dout,
    output logic            frame_err,
    output logic            parity_err,
    output logic            overrun_err,
    output logic            busy
);

    localparam int            NW        = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [4:0]    STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
    localparam logic [NW-1:0] N_ONE     = NW'(1);

    logic            w_rx_s;

    rx_state_t       r_state;
    rx_state_t       w_state_nxt;
    logic [4:0]      r_s;
    logic [4:0]      w_s_nxt;
    logic [NW-1:0]   r_n;
    logic [NW-1:0]   w_n_nxt;
    logic [DBIT-1:0] r_shift;
    logic [DBIT-1:0] w_shift_nxt;
    logic            r_par;
    logic            w_par_nxt;

    logic            w_done;
    logic            w_load;
    logic            w_drop;
    logic            w_fe;
    logic            w_pe;

    logic            r_valid;
    logic [DBIT-1:0] r_dout;
    logic            r_fe;
    logic            r_pe;
    logic            r_ovr;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rx_s  (w_rx_s)
    );

    // State register together with the frame datapath it sequences.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_n     <= w_n_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
        end
    end

    // Next-state: IDLE and BRK_WAIT follow the line directly, the
    // other states advance only on oversample ticks.
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_n_nxt     = r_n;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        unique case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = START;
                    w_s_nxt     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (r_s == MID_TICK) begin
                        if (!w_rx_s) begin
                            w_state_nxt = DATA;
                            w_s_nxt     = '0;
                            w_n_nxt     = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_s_nxt = r_s + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (r_s == LAST_TICK) begin
                        w_s_nxt     = '0;
                        w_shift_nxt = {w_rx_s, r_shift[DBIT-1:1]};
                        if (r_n == N_LAST) begin
                            w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            w_n_nxt = r_n + N_ONE;
                        end
                    end else begin
                        w_s_nxt = r_s + 5'd1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (r_s == LAST_TICK) begin
                        w_s_nxt     = '0;
                        w_par_nxt   = w_rx_s;
                        w_state_nxt = STOP;
                    end else begin
                        w_s_nxt = r_s + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (r_s == STOP_LAST) begin
                        w_s_nxt     = '0;
                        // A low stop bit parks in BRK_WAIT so a held
                        // break yields one frame, not a stream.
                        w_state_nxt = w_rx_s ? IDLE : BRK_WAIT;
                    end else begin
                        w_s_nxt = r_s + 5'd1;
                    end
                end
            end
            BRK_WAIT: begin
                if (w_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs and frame-completion decode.
    always_comb begin
        busy   = (r_state != IDLE);
        w_done = (r_state == STOP) && s_tick && (r_s == STOP_LAST);
        // Loading is allowed when the buffer drains in this same cycle.
        w_load = w_done && (!r_valid || rx_ready);
        w_drop = w_done && r_valid && !rx_ready;
        w_fe   = ~w_rx_s;
        w_pe   = (PARITY_EN != 0) &&
                 ((^r_shift) ^ r_par ^ (PARITY_ODD != 0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_dout  <= '0;
            r_fe    <= 1'b0;
            r_pe    <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= w_drop;
            if (w_load) begin
                r_valid <= 1'b1;
                r_dout  <= r_shift;
                r_fe    <= w_fe;
                r_pe    <= w_pe;
            end else if (rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_valid    = r_valid;
    assign dout        = r_dout;
    assign frame_err   = r_fe;
    assign parity_err  = r_pe;
    assign overrun_err = r_ovr;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: an 8N1 instance and an 8E1
// instance driven by a serial-line model with a M=27 tick generator.
module tb_uart_rx_ctrl;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic reset;
    logic s_tick = 1'b0;
    int   tcnt   = 0;

    always @(posedge clk) begin
        if (tcnt == 26) begin
            tcnt   <= 0;
            s_tick <= 1'b1;
        end else begin
            tcnt   <= tcnt + 1;
            s_tick <= 1'b0;
        end
    end

    logic       rx_d, rdy_d, val_d, fe_d, pe_d, ovr_d, busy_d;
    logic [7:0] dout_d;
    logic       rx_p, rdy_p, val_p, fe_p, pe_p, ovr_p, busy_p;
    logic [7:0] dout_p;

    uart_rx_ctrl u_dut (
        .clk         (clk),
        .reset       (reset),
        .s_tick      (s_tick),
        .rx          (rx_d),
        .rx_ready    (rdy_d),
        .rx_valid    (val_d),
        .dout        (dout_d),
        .frame_err   (fe_d),
        .parity_err  (pe_d),
        .overrun_err (ovr_d),
        .busy        (busy_d)
    );

    uart_rx_ctrl #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .clk         (clk),
        .reset       (reset),
        .s_tick      (s_tick),
        .rx          (rx_p),
        .rx_ready    (rdy_p),
        .rx_valid    (val_p),
        .dout        (dout_p),
        .frame_err   (fe_p),
        .parity_err  (pe_p),
        .overrun_err (ovr_p),
        .busy        (busy_p)
    );

    // Accepted bytes as {frame_err, parity_err, data}.
    logic [9:0] q_d[$];
    logic [9:0] q_p[$];
    int         ovr_cyc = 0;

    always @(posedge clk) begin
        if (val_d && rdy_d) q_d.push_back({fe_d, pe_d, dout_d});
        if (val_p && rdy_p) q_p.push_back({fe_p, pe_p, dout_p});
        if (ovr_d) ovr_cyc++;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (s_tick !== 1'b1) @(posedge clk);
        end
    endtask

    task automatic drive(input bit sel, input logic b);
        @(negedge clk);
        if (sel) rx_p = b;
        else     rx_d = b;
    endtask

    task automatic send(input bit sel, input logic [7:0] data,
                        input bit has_par, input logic pbit,
                        input logic stop);
        drive(sel, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            drive(sel, data[i]);
            wait_ticks(16);
        end
        if (has_par) begin
            drive(sel, pbit);
            wait_ticks(16);
        end
        drive(sel, stop);
        wait_ticks(16);
        drive(sel, 1'b1);
        wait_ticks(16);
    endtask

    task automatic expect_d(input string tag, input logic [9:0] exp);
        logic [9:0] got;
        got = 'x;
        if (q_d.size() != 0) got = q_d.pop_front();
        chk(tag, 32'(got), 32'(exp));
    endtask

    task automatic expect_p(input string tag, input logic [9:0] exp);
        logic [9:0] got;
        got = 'x;
        if (q_p.size() != 0) got = q_p.pop_front();
        chk(tag, 32'(got), 32'(exp));
    endtask

    // Reference: even parity error when the total count of ones is odd.
    function automatic logic even_err(input logic [7:0] d, input logic p);
        return logic'(($countones(d) + int'(p)) % 2);
    endfunction

    initial begin
        int         n0;
        int         o0;
        logic [7:0] d;
        logic       st;
        logic       pb;

        reset = 1'b1;
        rx_d  = 1'b1;
        rx_p  = 1'b1;
        rdy_d = 1'b1;
        rdy_p = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(val_d), 0);
        chk("rst_dout", 32'(dout_d), 0);
        chk("rst_fe", 32'(fe_d), 0);
        chk("rst_pe", 32'(pe_d), 0);
        chk("rst_ovr", 32'(ovr_d), 0);
        chk("rst_busy", 32'(busy_d), 0);
        reset = 1'b0;
        wait_ticks(4);

        n0 = q_d.size();
        send(0, 8'hA5, 0, 0, 1);
        chk("a5_count", 32'(q_d.size() - n0), 1);
        expect_d("a5_byte", {2'b00, 8'hA5});
        chk("a5_busy", 32'(busy_d), 0);
        chk("a5_valid_fell", 32'(val_d), 0);

        drive(0, 1'b0);
        wait_ticks(2);
        chk("glitch_busy", 32'(busy_d), 1);
        wait_ticks(2);
        drive(0, 1'b1);
        wait_ticks(12);
        @(negedge clk);
        chk("glitch_idle", 32'(busy_d), 0);
        chk("glitch_nobyte", 32'(q_d.size()), 0);

        drive(0, 1'b0);
        wait_ticks(30 * 16);
        @(negedge clk);
        chk("brk_count", 32'(q_d.size()), 1);
        expect_d("brk_byte", {2'b10, 8'h00});
        chk("brk_busy", 32'(busy_d), 1);
        drive(0, 1'b1);
        wait_ticks(32);
        @(negedge clk);
        chk("brk_release", 32'(busy_d), 0);
        chk("brk_nomore", 32'(q_d.size()), 0);
        send(0, 8'h5A, 0, 0, 1);
        expect_d("post_brk_5a", {2'b00, 8'h5A});

        for (int k = 0; k < 3; k++) begin
            d  = 8'($urandom_range(0, 255));
            st = 1'($urandom_range(0, 1));
            send(0, d, 0, 0, st);
            expect_d($sformatf("rand%0d", k), {~st, 1'b0, d});
        end

        send(1, 8'h07, 1, 1'b1, 1);
        expect_p("par_07_ok", {2'b00, 8'h07});
        send(1, 8'h07, 1, 1'b0, 1);
        expect_p("par_07_bad", {2'b01, 8'h07});
        for (int k = 0; k < 2; k++) begin
            d  = 8'($urandom_range(0, 255));
            pb = 1'($urandom_range(0, 1));
            send(1, d, 1, pb, 1);
            expect_p($sformatf("par_rand%0d", k),
                     {1'b0, even_err(d, pb), d});
        end

        @(negedge clk);
        rdy_d = 1'b0;
        o0    = ovr_cyc;
        send(0, 8'h11, 0, 0, 1);
        send(0, 8'h22, 0, 0, 1);
        @(negedge clk);
        chk("ovr_valid", 32'(val_d), 1);
        chk("ovr_dout", 32'(dout_d), 32'h11);
        chk("ovr_pulse", 32'(ovr_cyc - o0), 1);
        rdy_d = 1'b1;
        @(negedge clk);
        chk("ovr_drain", 32'(val_d), 0);
        expect_d("ovr_byte", {2'b00, 8'h11});
        wait_ticks(4);
        chk("ovr_dropped", 32'(q_d.size()), 0);

        drive(0, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1);
            wait_ticks(16);
        end
        drive(0, 1'b1);
        wait_ticks(8);
        @(negedge clk);
        chk("mid_busy_pre", 32'(busy_d), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_dout", 32'(dout_d), 0);
        chk("mid_rst_valid", 32'(val_d), 0);
        chk("mid_rst_busy", 32'(busy_d), 0);
        chk("mid_rst_fe", 32'(fe_d), 0);
        @(negedge clk);
        reset = 1'b0;
        wait_ticks(32);
        send(0, 8'h3C, 0, 0, 1);
        expect_d("post_rst_3c", {2'b00, 8'h3C});
        chk("final_empty", 32'(q_d.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
